wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back end of the execution-result interface (destination address, write-enable, write data).
- Combines the MEM/WB pipeline register and the 32x32 general-purpose register file.
- Captures each result, commits it to the register file one cycle later, and serves two combinational read ports to the decode stage.
- The read ports bypass the pending write-back value so a dependent instruction never reads stale data.

Parameters:
DATA_W, 32, width of register data (RegBus).
ADDR_W, 5, width of register address (RegAddrBus).
NUM_REGS, 32, number of architectural registers; register 0 is hardwired to zero.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
stall  input  1  hold the MEM/WB register contents.
flush  input  1  replace MEM/WB contents with a bubble.
in_wd  input  ADDR_W  destination register of the incoming result.
in_wreg  input  1  incoming result writes a register.
in_wdata  input  DATA_W  incoming result data.
re1  input  1  read port 1 enable.
raddr1  input  ADDR_W  read port 1 address.
rdata1  output  DATA_W  read port 1 data (combinational).
re2  input  1  read port 2 enable.
raddr2  input  ADDR_W  read port 2 address.
rdata2  output  DATA_W  read port 2 data (combinational).
wb_wd  output  ADDR_W  registered destination in the WB stage.
wb_wreg  output  1  registered write-enable in the WB stage.
wb_wdata  output  DATA_W  registered write data in the WB stage.

Behaviour:
- Reset (rst=1 at posedge):
  - wb_wd, wb_wreg and wb_wdata clear to 0.
  - All NUM_REGS registers clear to 0.
  - rst overrides stall, flush and any pending write; a write pending in the WB stage is discarded.
  - While rst=1, rdata1 and rdata2 are 0.
- MEM/WB register, evaluated each posedge with rst=0, in priority order:
  - flush=1: load bubble (wb_wd=0, wb_wreg=0, wb_wdata=0). Flush beats stall.
  - else stall=1: hold all wb_* values.
  - else: wb_* <= in_*.
- Commit:
  - At each posedge with rst=0, if wb_wreg=1 and wb_wd!=0, then regs[wb_wd] <= wb_wdata.
  - The commit uses the WB contents present before the edge, so it happens in the same edge at which a new result is captured.
  - Total latency from in_* presented to the register array updated: 2 rising edges.
- Stall while holding a valid write: the same value is rewritten each cycle; this is idempotent and allowed.
- Writes to register 0 are ignored at all times; regs[0] is always 0.
- Read port k (k=1,2), combinational, in priority order:
  - rst=1 -> 0
  - rek=0 -> 0
  - raddrk=0 -> 0
  - wb_wreg=1 and wb_wd==raddrk -> wb_wdata (bypass)
  - otherwise -> regs[raddrk]
- Both ports may read the same address; both may bypass simultaneously.
- No bypass from in_* directly. Forwarding from the EX and MEM stages is handled by the decode stage.
- Flush with wb_wreg=1 before the edge: the pending write still commits at that edge; only the newly captured entry becomes a bubble.
- All arithmetic is address compare only; there is no data manipulation. Data passes through unmodified at DATA_W bits.

Test Plan:
1. Reset then read: rst=1 for 2 cycles, then re1=1, raddr1=5 -> rdata1=0; wb_wreg=0.
2. Basic write/read:
   - Stimulus: in_wd=3, in_wreg=1, in_wdata=0x1234_5678 for one cycle.
   - After edge 1: wb_wd=3, wb_wdata=0x12345678, and rdata1 (raddr1=3) shows 0x12345678 via bypass.
   - After edge 2: in_wreg=0; the value comes from the array and rdata1 still reads 0x12345678.
3. Register 0 guard: write in_wd=0, in_wdata=0xFFFF_FFFF -> after 2 edges, rdata2 with raddr2=0 reads 0; no bypass occurs even while wb_wd=0 and wb_wreg=1.
4. Stall/flush:
   - Load wd=7, data=0xA5.
   - stall=1 with new in_wd=8, data=0x5A -> wb_* stays wd=7/0xA5.
   - Assert flush=1 and stall=1 together -> next cycle wb_wreg=0, and regs[7]=0xA5 is committed.
5. Dual-port and read enable:
   - regs[4]=0x11 and regs[9]=0x22; raddr1=4, raddr2=9, both enabled -> 0x11 and 0x22.
   - Drop re2 -> rdata2=0.
   - Set raddr1=raddr2=4 with a pending WB write of 0x99 to 4 -> both ports read 0x99.
6. Reset mid-operation: WB holds wd=6, data=0x77, wreg=1 and rst is asserted at that edge -> regs[6] stays 0 and wb_* is 0 after the edge.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage: MEM/WB pipeline register feeding a 32-entry register file
// with two combinational read ports that bypass the pending write-back value.
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] in_wd,
    input  logic              in_wreg,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata
);

    logic [ADDR_W-1:0] wb_wd_q, wb_wd_d;
    logic              wb_wreg_q, wb_wreg_d;
    logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;

    // Flush outranks stall so a squashed instruction never lingers in WB.
    always_comb begin
        wb_wd_d    = wb_wd_q;
        wb_wreg_d  = wb_wreg_q;
        wb_wdata_d = wb_wdata_q;
        if (flush) begin
            wb_wd_d    = '0;
            wb_wreg_d  = 1'b0;
            wb_wdata_d = '0;
        end else if (!stall) begin
            wb_wd_d    = in_wd;
            wb_wreg_d  = in_wreg;
            wb_wdata_d = in_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wd_q    <= '0;
            wb_wreg_q  <= 1'b0;
            wb_wdata_q <= '0;
        end else begin
            wb_wd_q    <= wb_wd_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_wdata_q <= wb_wdata_d;
        end
    end

    assign wb_wd    = wb_wd_q;
    assign wb_wreg  = wb_wreg_q;
    assign wb_wdata = wb_wdata_q;

    // Commit uses the WB contents from before the edge; register 0 never stores.
    logic commit_en;
    assign commit_en = wb_wreg_q && (wb_wd_q != '0);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                always_ff @(posedge clk) begin
                    regs_q[gi] <= '0;
                end
            end else begin : g_gpr
                always_ff @(posedge clk) begin
                    if (rst) begin
                        regs_q[gi] <= '0;
                    end else if (commit_en && (wb_wd_q == ADDR_W'(gi))) begin
                        regs_q[gi] <= wb_wdata_q;
                    end
                end
            end
        end
    endgenerate

    logic [1:0]        rd_en;
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    assign rd_en      = {re2, re1};
    assign rd_addr[0] = raddr1;
    assign rd_addr[1] = raddr2;

    // Address 0 is checked before the bypass so a pending write to r0 never leaks out.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            rd_data[k] = '0;
            if (!rst && rd_en[k] && (rd_addr[k] != '0)) begin
                if (wb_wreg_q && (wb_wd_q == rd_addr[k])) begin
                    rd_data[k] = wb_wdata_q;
                end else begin
                    rd_data[k] = regs_q[rd_addr[k]];
                end
            end
        end
    end

    assign rdata1 = rd_data[0];
    assign rdata2 = rd_data[1];

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: table-driven vectors with hand-derived read
// expectations, a WB-register scoreboard queue, and a randomized model-checked phase.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [4:0]  in_wd;
    logic        in_wreg;
    logic [31:0] in_wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;

    wb_regfile #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .NUM_REGS(32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .flush   (flush),
        .in_wd   (in_wd),
        .in_wreg (in_wreg),
        .in_wdata(in_wdata),
        .re1     (re1),
        .raddr1  (raddr1),
        .rdata1  (rdata1),
        .re2     (re2),
        .raddr2  (raddr2),
        .rdata2  (rdata2),
        .wb_wd   (wb_wd),
        .wb_wreg (wb_wreg),
        .wb_wdata(wb_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } wb_t;

    wb_t         sb_q[$];
    logic [31:0] m_regs [32];
    wb_t         m_wb;

    function automatic vec_t mk(input logic r, input logic s, input logic f,
                                input logic [4:0] wd, input logic wr, input logic [31:0] wdat,
                                input logic e1, input logic [4:0] a1,
                                input logic e2, input logic [4:0] a2,
                                input logic [31:0] x1, input logic [31:0] x2);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f;
        v.wd = wd; v.wreg = wr; v.wdata = wdat;
        v.re1 = e1; v.ra1 = a1; v.re2 = e2; v.ra2 = a2;
        v.exp1 = x1; v.exp2 = x2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] model_read(input logic e, input logic [4:0] a);
        if (rst || !e || a == 5'd0) return 32'h0;
        if (m_wb.wreg && m_wb.wd == a) return m_wb.wdata;
        return m_regs[a];
    endfunction

    // Drive one cycle of inputs, push the expected WB contents, advance one edge,
    // update the model and compare the WB register against the scoreboard.
    task automatic apply(input vec_t v);
        wb_t exp_wb;
        wb_t got;
        rst = v.rst; stall = v.stall; flush = v.flush;
        in_wd = v.wd; in_wreg = v.wreg; in_wdata = v.wdata;
        re1 = v.re1; raddr1 = v.ra1; re2 = v.re2; raddr2 = v.ra2;
        if (v.rst || v.flush) exp_wb = '{5'd0, 1'b0, 32'h0};
        else if (v.stall)     exp_wb = m_wb;
        else                  exp_wb = '{v.wd, v.wreg, v.wdata};
        sb_q.push_back(exp_wb);
        @(posedge clk);
        if (v.rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        end else if (m_wb.wreg && m_wb.wd != 5'd0) begin
            m_regs[m_wb.wd] = m_wb.wdata;
        end
        m_wb = exp_wb;
        #1;
        got = sb_q.pop_front();
        check("wb_wd",    {27'd0, wb_wd},   {27'd0, got.wd});
        check("wb_wreg",  {31'd0, wb_wreg}, {31'd0, got.wreg});
        check("wb_wdata", wb_wdata,         got.wdata);
    endtask

    vec_t vecs [20];

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        in_wd = '0; in_wreg = 1'b0; in_wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        m_wb = '{5'd0, 1'b0, 32'h0};
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;

        //            rst stl fl  wd     wr  wdata         re1 ra1    re2 ra2    exp1          exp2
        vecs[0]  = mk(1, 0, 0, 5'd0,  0, 32'h0,        1, 5'd5,  1, 5'd0,  32'h0,        32'h0);
        vecs[1]  = mk(1, 0, 0, 5'd0,  0, 32'h0,        1, 5'd5,  1, 5'd0,  32'h0,        32'h0);
        vecs[2]  = mk(0, 0, 0, 5'd3,  1, 32'h12345678, 1, 5'd3,  1, 5'd5,  32'h12345678, 32'h0);
        vecs[3]  = mk(0, 0, 0, 5'd0,  0, 32'h0,        1, 5'd3,  1, 5'd3,  32'h12345678, 32'h12345678);
        vecs[4]  = mk(0, 0, 0, 5'd0,  1, 32'hFFFFFFFF, 1, 5'd3,  1, 5'd0,  32'h12345678, 32'h0);
        vecs[5]  = mk(0, 0, 0, 5'd0,  0, 32'h0,        1, 5'd3,  1, 5'd0,  32'h12345678, 32'h0);
        vecs[6]  = mk(0, 0, 0, 5'd7,  1, 32'hA5,       1, 5'd7,  1, 5'd8,  32'hA5,       32'h0);
        vecs[7]  = mk(0, 1, 0, 5'd8,  1, 32'h5A,       1, 5'd7,  1, 5'd8,  32'hA5,       32'h0);
        vecs[8]  = mk(0, 1, 1, 5'd8,  1, 32'h5A,       1, 5'd7,  1, 5'd8,  32'hA5,       32'h0);
        vecs[9]  = mk(0, 0, 0, 5'd4,  1, 32'h11,       1, 5'd4,  1, 5'd9,  32'h11,       32'h0);
        vecs[10] = mk(0, 0, 0, 5'd9,  1, 32'h22,       1, 5'd4,  1, 5'd9,  32'h11,       32'h22);
        vecs[11] = mk(0, 0, 0, 5'd0,  0, 32'h0,        1, 5'd4,  1, 5'd9,  32'h11,       32'h22);
        vecs[12] = mk(0, 0, 0, 5'd0,  0, 32'h0,        1, 5'd4,  0, 5'd9,  32'h11,       32'h0);
        vecs[13] = mk(0, 0, 0, 5'd4,  1, 32'h99,       1, 5'd4,  1, 5'd4,  32'h99,       32'h99);
        vecs[14] = mk(0, 0, 0, 5'd0,  0, 32'h0,        1, 5'd4,  1, 5'd4,  32'h99,       32'h99);
        vecs[15] = mk(0, 0, 0, 5'd6,  1, 32'h77,       1, 5'd6,  1, 5'd9,  32'h77,       32'h22);
        vecs[16] = mk(1, 0, 0, 5'd0,  0, 32'h0,        1, 5'd6,  1, 5'd9,  32'h0,        32'h0);
        vecs[17] = mk(0, 0, 0, 5'd0,  0, 32'h0,        1, 5'd6,  1, 5'd9,  32'h0,        32'h0);
        vecs[18] = mk(0, 0, 0, 5'd5,  1, 32'hDEADBEEF, 0, 5'd5,  1, 5'd5,  32'h0,        32'hDEADBEEF);
        vecs[19] = mk(0, 0, 1, 5'd10, 1, 32'hCAFE,     1, 5'd5,  1, 5'd10, 32'hDEADBEEF, 32'h0);

        for (int i = 0; i < 20; i++) begin
            apply(vecs[i]);
            check($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].exp1);
            check($sformatf("vec%0d_rdata2", i), rdata2, vecs[i].exp2);
            $display("vec %0d: rdata1=%h rdata2=%h wb=%0d/%0d/%h",
                     i, rdata1, rdata2, wb_wd, wb_wreg, wb_wdata);
        end

        // Multi-cycle stall holding a write to r12, then release; the held write
        // commits repeatedly and the incoming r13 result is captured only afterwards.
        apply(mk(0, 0, 0, 5'd12, 1, 32'h1111, 1, 5'd12, 1, 5'd13, 32'h1111, 32'h0));
        for (int c = 0; c < 3; c++) begin
            apply(mk(0, 1, 0, 5'd13, 1, 32'h2222, 1, 5'd12, 1, 5'd13, 32'h1111, 32'h0));
            check("stall_rdata1", rdata1, 32'h1111);
            check("stall_rdata2", rdata2, 32'h0);
            $display("stall %0d: rdata1=%h rdata2=%h wb=%0d/%0d/%h",
                     c, rdata1, rdata2, wb_wd, wb_wreg, wb_wdata);
        end
        apply(mk(0, 0, 0, 5'd13, 1, 32'h2222, 1, 5'd12, 1, 5'd13, 32'h1111, 32'h2222));
        check("release_rdata1", rdata1, 32'h1111);
        check("release_rdata2", rdata2, 32'h2222);
        $display("release: rdata1=%h rdata2=%h wb=%0d/%0d/%h",
                 rdata1, rdata2, wb_wd, wb_wreg, wb_wdata);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 200; n++) begin
            vec_t v;
            v = mk(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0),
                   ($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), $urandom,
                   ($urandom_range(0, 5) != 0), 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 5) != 0), 5'($urandom_range(0, 31)),
                   32'h0, 32'h0);
            apply(v);
            check("rand_rdata1", rdata1, model_read(re1, raddr1));
            check("rand_rdata2", rdata2, model_read(re2, raddr2));
            $display("rand %0d: r1[%0d]=%h r2[%0d]=%h wb=%0d/%0d/%h",
                     n, raddr1, rdata1, raddr2, rdata2, wb_wd, wb_wreg, wb_wdata);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
